// File: rtl/reduce_table_engine_pkg.sv
// reduce_pkg: shared types and helpers for the reduction table engine.
// Optional macro REDUCE_TIMEOUT_EN adds a per-slot "partial" flag to the slot control word.
package reduce_pkg;

    localparam int OP_W   = 3;
    localparam int IDLE_W = 8;

    // Reduction operations; encodings 6 and 7 are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_MAX = 3'd1,
        OP_MIN = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } op_t;

    // Per-slot lifecycle.
    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_ACC  = 2'd1,
        SLOT_BUSY = 2'd2,
        SLOT_DONE = 2'd3
    } slot_state_t;

    // Width-independent part of a slot. The parameter-sized fields (dst,
    // remaining, payload) are appended in the engine, since a package
    // cannot take the engine's width parameters.
    typedef struct packed {
        slot_state_t      state;
        logic [OP_W-1:0]  op;
`ifdef REDUCE_TIMEOUT_EN
        logic             partial;
`endif
    } slot_ctl_t;

    // True for the six defined operations.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/reduce_table_engine_alu.sv
// reduce_alu: combinational reduction followed by an ALU_LAT-deep register
// pipeline carrying result, valid and slot index.
module reduce_alu
    import reduce_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 4,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              in_vld,
    input  logic [IDX_W-1:0]  in_idx,
    output logic [DATA_W-1:0] res,
    output logic              out_vld,
    output logic [IDX_W-1:0]  out_idx
);

    logic [DATA_W-1:0] res_comb;

    // Unsigned reduction; ADD wraps modulo 2^DATA_W.
    always_comb begin
        res_comb = '0;
        case (op)
            OP_ADD:  res_comb = a + b;
            OP_MAX:  res_comb = (a > b) ? a : b;
            OP_MIN:  res_comb = (a < b) ? a : b;
            OP_AND:  res_comb = a & b;
            OP_OR:   res_comb = a | b;
            OP_XOR:  res_comb = a ^ b;
            default: res_comb = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < ALU_LAT; gi++) begin : g_stage
            logic              vld_q;
            logic [DATA_W-1:0] data_q;
            logic [IDX_W-1:0]  idx_q;
            logic              vld_d;
            logic [DATA_W-1:0] data_d;
            logic [IDX_W-1:0]  idx_d;

            if (gi == 0) begin : g_src
                assign vld_d  = in_vld;
                assign data_d = res_comb;
                assign idx_d  = in_idx;
            end else begin : g_src
                assign vld_d  = g_stage[gi-1].vld_q;
                assign data_d = g_stage[gi-1].data_q;
                assign idx_d  = g_stage[gi-1].idx_q;
            end

            // One pipeline stage; reset flushes in-flight operations.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                    idx_q  <= '0;
                end else begin
                    vld_q  <= vld_d;
                    data_q <= data_d;
                    idx_q  <= idx_d;
                end
            end
        end
    endgenerate

    assign res     = g_stage[ALU_LAT-1].data_q;
    assign out_vld = g_stage[ALU_LAT-1].vld_q;
    assign out_idx = g_stage[ALU_LAT-1].idx_q;

endmodule

// File: rtl/reduce_table_engine.sv
// reduce_table_engine: in-network reduction table. Contributions with the same
// slot index are merged through reduce_alu; a completed slot is emitted once
// on the valid/ready output stream, lowest index first.
// Optional macro REDUCE_TIMEOUT_EN: per-slot idle timeout flushing partial results.
module reduce_table_engine
    import reduce_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_SLOTS   = 8,
    parameter int CHILD_W     = 3,
    parameter int ALU_LAT     = 4,
    parameter int NODE_W      = 3,
    parameter int RANK        = 0,
    parameter int TIMEOUT_CYC = 255,
    localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_index,
    input  logic [CHILD_W-1:0] in_children,
    input  logic [2:0]         in_op,
    input  logic [NODE_W-1:0]  in_dst,
    input  logic [DATA_W-1:0]  in_payload,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [2:0]         out_op,
    output logic [NODE_W-1:0]  out_dst,
    output logic [NODE_W-1:0]  out_src,
    output logic [DATA_W-1:0]  out_payload,
    output logic               out_partial,
    output logic               err_pulse
);

    typedef struct packed {
        slot_ctl_t          ctl;
        logic [NODE_W-1:0]  dst;
        logic [CHILD_W-1:0] remaining;
        logic [DATA_W-1:0]  payload;
    } slot_t;

    localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W+1)'(NUM_SLOTS);

    slot_t slots_reg  [NUM_SLOTS];
    slot_t slots_next [NUM_SLOTS];

    logic               idx_ok;
    logic [IDX_W-1:0]   sel_idx;
    slot_t              sel_slot;
    logic               accept;
    logic               drop;
    logic               do_alloc;
    logic               do_issue;

    logic [NUM_SLOTS-1:0] done_vec;
    logic                 any_done;
    logic [IDX_W-1:0]     done_idx;
    logic                 load_en;

    logic [DATA_W-1:0]  wb_res;
    logic               wb_vld;
    logic [IDX_W-1:0]   wb_idx;

    logic               out_valid_reg;
    logic [IDX_W-1:0]   out_index_reg;
    logic [2:0]         out_op_reg;
    logic [NODE_W-1:0]  out_dst_reg;
    logic [DATA_W-1:0]  out_payload_reg;
    logic               err_reg;

`ifdef REDUCE_TIMEOUT_EN
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC);
    logic [IDLE_W-1:0] idle_reg  [NUM_SLOTS];
    logic [IDLE_W-1:0] idle_next [NUM_SLOTS];
    logic              out_partial_reg;
`endif

    // Out-of-range indices never address the table; they are only dropped.
    assign idx_ok   = ({1'b0, in_index} < SLOT_LIMIT);
    assign sel_idx  = idx_ok ? in_index : '0;
    assign sel_slot = slots_reg[sel_idx];

    assign drop     = !idx_ok || !op_legal(in_op) ||
                      ((sel_slot.ctl.state == SLOT_ACC) && (sel_slot.ctl.op != in_op));
    assign accept   = in_valid && in_ready;
    assign do_alloc = accept && !drop && (sel_slot.ctl.state == SLOT_FREE);
    assign do_issue = accept && !drop && (sel_slot.ctl.state == SLOT_ACC);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_done
            assign done_vec[gi] = (slots_reg[gi].ctl.state == SLOT_DONE);
        end
    endgenerate

    // Lowest-index DONE slot wins the output register.
    always_comb begin
        any_done = 1'b0;
        done_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (done_vec[i]) begin
                any_done = 1'b1;
                done_idx = IDX_W'(i);
            end
        end
    end

    assign load_en = any_done && (!out_valid_reg || out_ready);

    // Back-pressure: busy/done slots and the slot being unloaded refuse input.
    always_comb begin
        in_ready = 1'b1;
        if (idx_ok) begin
            if ((sel_slot.ctl.state == SLOT_BUSY) || (sel_slot.ctl.state == SLOT_DONE))
                in_ready = 1'b0;
            if (load_en && (done_idx == in_index))
                in_ready = 1'b0;
        end
    end

    reduce_alu #(
        .DATA_W  (DATA_W),
        .ALU_LAT (ALU_LAT),
        .IDX_W   (IDX_W)
    ) u_alu (
        .clk     (clk),
        .rst     (rst),
        .a       (sel_slot.payload),
        .b       (in_payload),
        .op      (in_op),
        .in_vld  (do_issue),
        .in_idx  (in_index),
        .res     (wb_res),
        .out_vld (wb_vld),
        .out_idx (wb_idx)
    );

    // Per-slot next state: allocate, issue, timeout, writeback, unload.
    always_comb begin
        slots_next = slots_reg;
`ifdef REDUCE_TIMEOUT_EN
        idle_next = idle_reg;
`endif
        for (int i = 0; i < NUM_SLOTS; i++) begin
            case (slots_reg[i].ctl.state)
                SLOT_FREE: begin
                    if (do_alloc && (in_index == IDX_W'(i))) begin
                        slots_next[i].ctl.state = (in_children == '0) ? SLOT_DONE : SLOT_ACC;
                        slots_next[i].ctl.op    = in_op;
                        slots_next[i].dst       = in_dst;
                        slots_next[i].remaining = in_children;
                        slots_next[i].payload   = in_payload;
`ifdef REDUCE_TIMEOUT_EN
                        slots_next[i].ctl.partial = 1'b0;
                        idle_next[i]              = '0;
`endif
                    end
                end
                SLOT_ACC: begin
                    // A contribution beats a coincident timeout.
                    if (do_issue && (in_index == IDX_W'(i))) begin
                        slots_next[i].ctl.state = SLOT_BUSY;
`ifdef REDUCE_TIMEOUT_EN
                        idle_next[i] = '0;
                    end else if (idle_reg[i] == IDLE_LIMIT) begin
                        slots_next[i].ctl.state   = SLOT_DONE;
                        slots_next[i].ctl.partial = 1'b1;
                    end else begin
                        idle_next[i] = idle_reg[i] + 1'b1;
`endif
                    end
                end
                SLOT_BUSY: begin
                    if (wb_vld && (wb_idx == IDX_W'(i))) begin
                        slots_next[i].payload   = wb_res;
                        slots_next[i].remaining = slots_reg[i].remaining - 1'b1;
                        slots_next[i].ctl.state = (slots_reg[i].remaining == CHILD_W'(1)) ?
                                                  SLOT_DONE : SLOT_ACC;
`ifdef REDUCE_TIMEOUT_EN
                        idle_next[i] = '0;
`endif
                    end
                end
                SLOT_DONE: begin
                    if (load_en && (done_idx == IDX_W'(i)))
                        slots_next[i].ctl.state = SLOT_FREE;
                end
                default: ;
            endcase
        end
    end

    // Slot table register; reset frees every slot and drops partial results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_reg[i] <= '0;
`ifdef REDUCE_TIMEOUT_EN
                idle_reg[i]  <= '0;
`endif
            end
        end else begin
            slots_reg <= slots_next;
`ifdef REDUCE_TIMEOUT_EN
            idle_reg  <= idle_next;
`endif
        end
    end

    // Output register and drop indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_index_reg   <= '0;
            out_op_reg      <= '0;
            out_dst_reg     <= '0;
            out_payload_reg <= '0;
            err_reg         <= 1'b0;
`ifdef REDUCE_TIMEOUT_EN
            out_partial_reg <= 1'b0;
`endif
        end else begin
            if (load_en) begin
                out_valid_reg   <= 1'b1;
                out_index_reg   <= done_idx;
                out_op_reg      <= slots_reg[done_idx].ctl.op;
                out_dst_reg     <= slots_reg[done_idx].dst;
                out_payload_reg <= slots_reg[done_idx].payload;
`ifdef REDUCE_TIMEOUT_EN
                out_partial_reg <= slots_reg[done_idx].ctl.partial;
`endif
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            err_reg <= accept && drop;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_index   = out_index_reg;
    assign out_op      = out_op_reg;
    assign out_dst     = out_dst_reg;
    assign out_payload = out_payload_reg;
    assign out_src     = NODE_W'(RANK);
    assign err_pulse   = err_reg;
`ifdef REDUCE_TIMEOUT_EN
    assign out_partial = out_partial_reg;
`else
    assign out_partial = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_table_engine.sv
// Directed testbench for reduce_table_engine (six slots so that index 6 is out of range).
module tb_reduce_table_engine;

    localparam int DATA_W      = 32;
    localparam int NUM_SLOTS   = 6;
    localparam int CHILD_W     = 3;
    localparam int ALU_LAT     = 4;
    localparam int NODE_W      = 3;
    localparam int RANK        = 5;
    localparam int TIMEOUT_CYC = 40;
    localparam int IDX_W       = 3;

    localparam logic [2:0] C_ADD = 3'd0;
    localparam logic [2:0] C_MAX = 3'd1;
    localparam logic [2:0] C_MIN = 3'd2;
    localparam logic [2:0] C_XOR = 3'd5;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [IDX_W-1:0]   in_index;
    logic [CHILD_W-1:0] in_children;
    logic [2:0]         in_op;
    logic [NODE_W-1:0]  in_dst;
    logic [DATA_W-1:0]  in_payload;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_index;
    logic [2:0]         out_op;
    logic [NODE_W-1:0]  out_dst;
    logic [NODE_W-1:0]  out_src;
    logic [DATA_W-1:0]  out_payload;
    logic               out_partial;
    logic               err_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reduce_table_engine #(
        .DATA_W      (DATA_W),
        .NUM_SLOTS   (NUM_SLOTS),
        .CHILD_W     (CHILD_W),
        .ALU_LAT     (ALU_LAT),
        .NODE_W      (NODE_W),
        .RANK        (RANK),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_index    (in_index),
        .in_children (in_children),
        .in_op       (in_op),
        .in_dst      (in_dst),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_op      (out_op),
        .out_dst     (out_dst),
        .out_src     (out_src),
        .out_payload (out_payload),
        .out_partial (out_partial),
        .err_pulse   (err_pulse)
    );

    // Present one contribution for one clock (called at a negedge, returns at the next negedge).
    task automatic drive(input logic [2:0] idx, input logic [2:0] ch, input logic [2:0] op,
                         input logic [2:0] dst, input logic [31:0] pl, output logic rdy);
        in_index    = idx;
        in_children = ch;
        in_op       = op;
        in_dst      = dst;
        in_payload  = pl;
        in_valid    = 1'b1;
        #1 rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn in  idx=%0d op=%0d children=%0d payload=0x%h ready=%0b cyc=%0d",
                 idx, op, ch, pl, rdy, cyc);
    endtask

    // Wait (bounded) at negedges for out_valid.
    task automatic wait_out(input int max_cyc, output logic seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                at   = cyc;
                $display("txn out idx=%0d op=%0d dst=%0d payload=0x%h partial=%0b cyc=%0d",
                         out_index, out_op, out_dst, out_payload, out_partial, cyc);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        in_index = '0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_pulse); end
        n_cmp++; if (out_partial !== 1'b0) begin n_bad++; $display("FAIL reset_partial: got %b want 0", out_partial); end
        n_cmp++; if ({out_index, out_op, out_dst, out_payload} !== '0) begin
            n_bad++; $display("FAIL reset_fields: got idx=%0d op=%0d dst=%0d payload=0x%h want all 0",
                              out_index, out_op, out_dst, out_payload);
        end
        n_cmp++; if (out_src !== 3'd5) begin n_bad++; $display("FAIL reset_src: got %0d want 5", out_src); end
    endtask

    task automatic test_leaf();
        logic rdy;
        drive(3'd2, 3'd0, C_ADD, 3'd4, 32'h5, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL leaf_ready: got %b want 1", rdy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL leaf_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL leaf_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_index !== 3'd2) begin n_bad++; $display("FAIL leaf_index: got %0d want 2", out_index); end
        n_cmp++; if (out_payload !== 32'h5) begin n_bad++; $display("FAIL leaf_payload: got 0x%h want 0x5", out_payload); end
        n_cmp++; if (out_src !== 3'd5) begin n_bad++; $display("FAIL leaf_src: got %0d want 5", out_src); end
        n_cmp++; if (out_dst !== 3'd4) begin n_bad++; $display("FAIL leaf_dst: got %0d want 4", out_dst); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL leaf_pop: got %b want 0", out_valid); end
    endtask

    task automatic test_add_chain();
        logic rdy;
        logic seen;
        int   at;
        int   v2;
        int   v3;
        drive(3'd1, 3'd2, C_ADD, 3'd3, 32'd10, rdy);
        drive(3'd1, 3'd0, C_ADD, 3'd0, 32'd20, rdy);
        v2 = cyc;
        in_index = 3'd1;
        in_op    = C_ADD;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL add_busy_ready: got %b want 0", in_ready); end
        for (int k = 0; k < ALU_LAT + 4; k++) begin
            if (in_ready) break;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (cyc - v2 !== ALU_LAT) begin n_bad++; $display("FAIL add_busy_len: got %0d want %0d", cyc - v2, ALU_LAT); end
        @(negedge clk);
        drive(3'd1, 3'd0, C_ADD, 3'd0, 32'd30, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL add_third_ready: got %b want 1", rdy); end
        v3 = cyc;
        wait_out(ALU_LAT + 10, seen, at);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL add_seen: got %b want 1", seen); end
        n_cmp++; if (at - v3 !== ALU_LAT + 1) begin n_bad++; $display("FAIL add_latency: got %0d want %0d", at - v3, ALU_LAT + 1); end
        n_cmp++; if (out_payload !== 32'd60) begin n_bad++; $display("FAIL add_payload: got %0d want 60", out_payload); end
        n_cmp++; if (out_index !== 3'd1) begin n_bad++; $display("FAIL add_index: got %0d want 1", out_index); end
        n_cmp++; if (out_dst !== 3'd3) begin n_bad++; $display("FAIL add_dst: got %0d want 3", out_dst); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_single: got %b want 0", out_valid); end
    endtask

    task automatic test_ops();
        logic [2:0]  t_slot [4] = '{3'd0, 3'd3, 3'd4, 3'd5};
        logic [2:0]  t_op   [4] = '{C_ADD, C_MAX, C_MIN, C_XOR};
        logic [31:0] t_a    [4] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'h0000_00F0};
        logic [31:0] t_b    [4] = '{32'h2, 32'h8000_0000, 32'h8000_0000, 32'h0000_000F};
        logic [31:0] t_exp  [4] = '{32'h1, 32'h8000_0000, 32'h7, 32'h0000_00FF};
        logic rdy;
        logic seen;
        int   at;
        for (int t = 0; t < 4; t++) begin
            drive(t_slot[t], 3'd1, t_op[t], 3'd2, t_a[t], rdy);
            drive(t_slot[t], 3'd0, t_op[t], 3'd0, t_b[t], rdy);
            wait_out(ALU_LAT + 10, seen, at);
            n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL ops%0d_seen: got %b want 1", t, seen); end
            n_cmp++; if (out_payload !== t_exp[t]) begin
                n_bad++; $display("FAIL ops%0d_payload: got 0x%h want 0x%h", t, out_payload, t_exp[t]);
            end
            n_cmp++; if (out_op !== t_op[t]) begin n_bad++; $display("FAIL ops%0d_op: got %0d want %0d", t, out_op, t_op[t]); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        out_ready = 1'b0;
        drive(3'd0, 3'd0, C_ADD, 3'd1, 32'hA0, rdy);
        drive(3'd4, 3'd0, C_ADD, 3'd1, 32'hA4, rdy);
        drive(3'd1, 3'd0, C_ADD, 3'd1, 32'hA1, rdy);
        in_index = 3'd1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_done_ready: got %b want 0", in_ready); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({out_valid, out_index, out_payload} !== {1'b1, 3'd0, 32'hA0}) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b idx=%0d payload=0x%h want v=1 idx=0 payload=0xa0",
                                  k, out_valid, out_index, out_payload);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({out_valid, out_index, out_payload} !== {1'b1, 3'd1, 32'hA1}) begin
            n_bad++; $display("FAIL bp_second: got v=%b idx=%0d payload=0x%h want v=1 idx=1 payload=0xa1",
                              out_valid, out_index, out_payload);
        end
        @(negedge clk);
        n_cmp++; if ({out_valid, out_index, out_payload} !== {1'b1, 3'd4, 32'hA4}) begin
            n_bad++; $display("FAIL bp_third: got v=%b idx=%0d payload=0x%h want v=1 idx=4 payload=0xa4",
                              out_valid, out_index, out_payload);
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_errors();
        logic rdy;
        logic seen;
        int   at;
        drive(3'd2, 3'd1, C_ADD, 3'd6, 32'h100, rdy);
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL err_alloc: got %b want 0", err_pulse); end
        drive(3'd2, 3'd0, 3'd6, 3'd0, 32'hDEAD, rdy);
        n_cmp++; if ({rdy, err_pulse} !== 2'b11) begin n_bad++; $display("FAIL err_illegal_op: got rdy,err=%b%b want 11", rdy, err_pulse); end
        @(negedge clk);
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL err_width: got %b want 0", err_pulse); end
        drive(3'd2, 3'd0, C_MAX, 3'd0, 32'h999, rdy);
        n_cmp++; if ({rdy, err_pulse} !== 2'b11) begin n_bad++; $display("FAIL err_op_mismatch: got rdy,err=%b%b want 11", rdy, err_pulse); end
        drive(3'd6, 3'd0, C_ADD, 3'd0, 32'h55, rdy);
        n_cmp++; if ({rdy, err_pulse} !== 2'b11) begin n_bad++; $display("FAIL err_range: got rdy,err=%b%b want 11", rdy, err_pulse); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL err_no_output: got %b want 0", out_valid); end
        drive(3'd2, 3'd0, C_ADD, 3'd0, 32'h23, rdy);
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL err_good: got %b want 0", err_pulse); end
        wait_out(ALU_LAT + 10, seen, at);
        n_cmp++; if ({seen, out_index, out_dst, out_payload} !== {1'b1, 3'd2, 3'd6, 32'h123}) begin
            n_bad++; $display("FAIL err_slot_kept: got seen=%b idx=%0d dst=%0d payload=0x%h want seen=1 idx=2 dst=6 payload=0x123",
                              seen, out_index, out_dst, out_payload);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic rdy;
        logic seen;
        logic saw;
        int   at;
        drive(3'd3, 3'd1, C_ADD, 3'd2, 32'h1, rdy);
        drive(3'd3, 3'd0, C_ADD, 3'd0, 32'h2, rdy);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < ALU_LAT + 4; k++) begin
            if (out_valid) saw = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rstmid_output: got %b want 0", saw); end
        in_index = 3'd3;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        @(negedge clk);
        drive(3'd3, 3'd0, C_ADD, 3'd1, 32'h77, rdy);
        wait_out(8, seen, at);
        n_cmp++; if ({seen, out_payload} !== {1'b1, 32'h77}) begin
            n_bad++; $display("FAIL rstmid_fresh: got seen=%b payload=0x%h want seen=1 payload=0x77", seen, out_payload);
        end
        @(negedge clk);
    endtask

`ifdef REDUCE_TIMEOUT_EN
    task automatic test_timeout();
        logic rdy;
        logic seen;
        int   at;
        int   v2;
        drive(3'd5, 3'd2, C_ADD, 3'd1, 32'h10, rdy);
        drive(3'd5, 3'd0, C_ADD, 3'd0, 32'h20, rdy);
        v2 = cyc;
        wait_out(TIMEOUT_CYC + ALU_LAT + 20, seen, at);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL tmo_seen: got %b want 1", seen); end
        n_cmp++; if (at - v2 < TIMEOUT_CYC) begin n_bad++; $display("FAIL tmo_early: got %0d cycles want >= %0d", at - v2, TIMEOUT_CYC); end
        n_cmp++; if ({out_partial, out_index, out_payload} !== {1'b1, 3'd5, 32'h30}) begin
            n_bad++; $display("FAIL tmo_result: got partial=%b idx=%0d payload=0x%h want partial=1 idx=5 payload=0x30",
                              out_partial, out_index, out_payload);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_index    = '0;
        in_children = '0;
        in_op       = '0;
        in_dst      = '0;
        in_payload  = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        @(negedge clk);
        test_leaf();
        test_add_chain();
        test_ops();
        test_back_to_back();
        test_errors();
        test_reset_mid();
`ifdef REDUCE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
